mac_scheduler: RTL and testbench

Shares one square-accumulate datapath among NCH requesting channels. A round-robin arbiter accepts at most one 8-bit sample per cycle. Each sample is squared and added into that channel's own accumulator. After LEN samples on a channel, the block emits the channel's sum of squares with a one-cycle `out_valid` pulse and clears that channel's context. It sits between the sample producers and the result consumer, in place of a dedicated MAC per stream.

---
 rtl/mac_sched_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/mac_scheduler.sv | 110 +++++++++++
 tb/tb_mac_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_sched_pkg.sv
// Shared constants, types and the squaring helper for the shared square-accumulate scheduler.
package mac_sched_pkg;
  localparam int NCH_D = 4;
  localparam int LEN_D = 8;
  localparam int DW_D  = 8;
  localparam int AW_D  = 20;

  typedef logic [$clog2(NCH_D)-1:0] ch_id_t;
  typedef logic [AW_D-1:0]          acc_t;

  function automatic acc_t sq_ext(input logic [DW_D-1:0] a);
    logic [2*DW_D-1:0] p;
    p = {{DW_D{1'b0}}, a} * {{DW_D{1'b0}}, a};
    return acc_t'(p);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over N requesters; the pointer moves past the winner on acceptance.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id
);
  logic [IW-1:0] rr;
  logic [IW-1:0] idx;

  // Scan from farthest to nearest so the requester closest to rr is written last and wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = '0;
    if (enable && reset) begin
      for (int k = N-1; k >= 0; k--) begin
        idx = IW'((int'(rr) + k) % N);
        if (req[idx]) begin
          grant      = '0;
          grant[idx] = 1'b1;
          grant_id   = idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      rr <= '0;
    else if (accept) rr <= (int'(grant_id) == N-1) ? '0 : grant_id + IW'(1);
  end
endmodule

// File: rtl/mac_scheduler.sv
// Shares one square-accumulate datapath among NCH channels; emits each channel's sum of LEN squares.
module mac_scheduler
  import mac_sched_pkg::*;
#(
  parameter int NCH = NCH_D,
  parameter int LEN = LEN_D,
  parameter int DW  = DW_D,
  parameter int AW  = AW_D
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NCH-1:0]          req_valid,
  input  logic [NCH*DW-1:0]       req_a,
  output logic [NCH-1:0]          req_ready,
  input  logic [NCH-1:0]          clr,
  output logic                    out_valid,
  output logic [$clog2(NCH)-1:0]  out_ch,
  output logic [AW-1:0]           out_f
);
  localparam int IW = $clog2(NCH);
  localparam int CW = $clog2(LEN+1);
  localparam logic [CW-1:0] LAST = CW'(LEN-1);

  logic [IW-1:0] gid;
  logic          accept;
  logic [DW-1:0] a_arr [NCH];

  logic          s1_vld;
  logic [DW-1:0] s1_a;
  logic [IW-1:0] s1_ch;

  logic [AW-1:0] acc [NCH];
  logic [CW-1:0] cnt [NCH];
  logic [AW-1:0] sq, sum;
  logic          done;

  for (genvar i = 0; i < NCH; i++) begin : g_a
    assign a_arr[i] = req_a[i*DW +: DW];
  end

  assign accept = |(req_valid & req_ready);

  rr_arbiter #(.N(NCH)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .req      (req_valid),
    .accept   (accept),
    .grant    (req_ready),
    .grant_id (gid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld <= 1'b0;
      s1_a   <= '0;
      s1_ch  <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_a  <= a_arr[gid];
        s1_ch <= gid;
      end
    end
  end

  if (DW == DW_D && AW == AW_D) begin : g_sq_pkg
    assign sq = sq_ext(s1_a);
  end else begin : g_sq
    assign sq = AW'({{DW{1'b0}}, s1_a} * {{DW{1'b0}}, s1_a});
  end

  // acc is always current here: the previous edge already folded in any earlier sample.
  assign sum  = acc[s1_ch] + sq;
  assign done = s1_vld && !clr[s1_ch] && (cnt[s1_ch] == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clr[i] || (s1_vld && s1_ch == IW'(i) && cnt[i] == LAST)) begin
          acc[i] <= '0;
          cnt[i] <= '0;
        end else if (s1_vld && s1_ch == IW'(i)) begin
          acc[i] <= sum;
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_f     <= '0;
    end else begin
      out_valid <= done;
      if (done) begin
        out_f  <= sum;
        out_ch <= s1_ch;
      end
    end
  end
endmodule

// File: tb/tb_mac_scheduler.sv
// Scenario and randomized checks of mac_scheduler against a per-channel sum-of-squares model.
module tb_mac_scheduler;
  localparam int NCH = 4, LEN = 8, DW = 8, AW = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              enable = 1'b0;
  logic [NCH-1:0]    req_valid = '0;
  logic [NCH*DW-1:0] req_a = '0;
  logic [NCH-1:0]    clr = '0;
  logic [NCH-1:0]    req_ready;
  logic              out_valid;
  logic [1:0]        out_ch;
  logic [AW-1:0]     out_f;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mac_scheduler #(.NCH(NCH), .LEN(LEN), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(rst_n), .enable(enable), .req_valid(req_valid), .req_a(req_a),
    .req_ready(req_ready), .clr(clr), .out_valid(out_valid), .out_ch(out_ch), .out_f(out_f)
  );

  // Reference: rr search, per-channel running sum/count, one accepted sample waiting to be folded in.
  int     m_rr = 0;
  longint m_sum [NCH] = '{default: 0};
  int     m_n   [NCH] = '{default: 0};
  bit     pend_v = 0;
  int     pend_ch = 0, pend_a = 0, mg = -1;
  bit     e_ov = 0;
  int     e_ch = 0;
  longint e_f = 0;

  function automatic int arb();
    if (!rst_n || !enable) return -1;
    for (int k = 0; k < NCH; k++)
      if (req_valid[(m_rr + k) % NCH]) return (m_rr + k) % NCH;
    return -1;
  endfunction

  function automatic logic [NCH-1:0] exp_ready();
    logic [NCH-1:0] r;
    int g;
    r = '0;
    g = arb();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_rr = 0; pend_v = 0; e_ov = 0; e_ch = 0; e_f = 0;
      for (int i = 0; i < NCH; i++) begin m_sum[i] = 0; m_n[i] = 0; end
    end else begin
      mg = arb();
      e_ov = 0;
      for (int i = 0; i < NCH; i++) if (clr[i]) begin m_sum[i] = 0; m_n[i] = 0; end
      if (pend_v && !clr[pend_ch]) begin
        m_sum[pend_ch] += longint'(pend_a) * pend_a;
        m_n[pend_ch]++;
        if (m_n[pend_ch] == LEN) begin
          e_ov = 1; e_ch = pend_ch; e_f = m_sum[pend_ch];
          m_sum[pend_ch] = 0; m_n[pend_ch] = 0;
        end
      end
      pend_v = (mg >= 0);
      if (mg >= 0) begin
        pend_ch = mg;
        pend_a  = int'(req_a[mg*DW +: DW]);
        m_rr    = (mg + 1) % NCH;
      end
    end
  end

  task automatic test_reset();
    #2 rst_n = 1'b0;
    enable = 1'b1; req_valid = '1; req_a = 32'($urandom);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nchk++; if (req_ready !== '0) begin nerr++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
      nchk++; if ({out_valid, out_ch, out_f} !== '0) begin nerr++;
        $display("FAIL reset_out got v=%b ch=%0d f=%0d exp all 0", out_valid, out_ch, out_f); end
    end
    @(posedge clk); #1; rst_n = 1'b1; req_valid = '0;
    @(negedge clk);
    nchk++; if (req_ready !== exp_ready()) begin nerr++; $display("FAIL reset_release_ready got=%b exp=%b", req_ready, exp_ready()); end
  endtask

  task automatic test_single();
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      req_valid = (c < 8) ? 4'b0001 : 4'b0000;
      if (c < 8) req_a[7:0] = 8'(c + 1);
      @(negedge clk);
      nchk++; if (req_ready !== exp_ready()) begin nerr++; $display("FAIL single_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready()); end
      nchk++; if (out_valid !== (c == 9)) begin nerr++; $display("FAIL single_pulse c=%0d got=%b exp=%b", c, out_valid, (c == 9)); end
      if (c == 9) begin
        nchk++; if (out_ch !== 2'd0 || out_f !== 20'd204) begin nerr++;
          $display("FAIL single_result got ch=%0d f=%0d exp ch=0 f=204", out_ch, out_f); end
      end
    end
  endtask

  task automatic test_contention();
    int pc[$], pcy[$];
    longint pf[$];
    logic [NCH-1:0] seen;
    seen = '0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      req_a = {8'd4, 8'd3, 8'd2, 8'd1};
      req_valid = (c < 32) ? '1 : '0;
      @(negedge clk);
      nchk++; if (req_ready !== exp_ready()) begin nerr++; $display("FAIL cont_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready()); end
      nchk++; if ({out_valid, out_ch, out_f} !== {e_ov, 2'(e_ch), AW'(e_f)}) begin nerr++;
        $display("FAIL cont_out c=%0d got v=%b ch=%0d f=%0d exp v=%b ch=%0d f=%0d", c, out_valid, out_ch, out_f, e_ov, e_ch, e_f); end
      if (out_valid) begin pc.push_back(int'(out_ch)); pf.push_back(longint'(out_f)); pcy.push_back(c); end
    end
    nchk++;
    if (pc.size() != 4) begin nerr++; $display("FAIL cont_count got=%0d exp=4", pc.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        nchk++;
        if (pf[k] != 8 * (pc[k] + 1) * (pc[k] + 1) || pcy[k] != 30 + k) begin nerr++;
          $display("FAIL cont_result k=%0d got ch=%0d f=%0d cyc=%0d exp f=%0d cyc=%0d", k, pc[k], pf[k], pcy[k], 8*(pc[k]+1)*(pc[k]+1), 30+k); end
        seen[pc[k]] = 1'b1;
      end
      nchk++; if (seen !== 4'b1111) begin nerr++; $display("FAIL cont_channels got=%b exp=1111", seen); end
    end
  endtask

  task automatic test_max();
    int pc[$], pcy[$];
    longint pf[$];
    for (int c = 0; c < 22; c++) begin
      @(posedge clk); #1;
      req_valid = (c < 16) ? 4'b0100 : 4'b0000;
      req_a[23:16] = (c < 8) ? 8'd255 : 8'd1;
      @(negedge clk);
      nchk++; if ({out_valid, out_ch, out_f} !== {e_ov, 2'(e_ch), AW'(e_f)}) begin nerr++;
        $display("FAIL max_out c=%0d got v=%b ch=%0d f=%0d exp v=%b ch=%0d f=%0d", c, out_valid, out_ch, out_f, e_ov, e_ch, e_f); end
      if (out_valid) begin pc.push_back(int'(out_ch)); pf.push_back(longint'(out_f)); pcy.push_back(c); end
    end
    nchk++;
    if (pc.size() != 2) begin nerr++; $display("FAIL max_count got=%0d exp=2", pc.size()); end
    else begin
      nchk++; if (pc[0] != 2 || pf[0] != 520200 || pcy[0] != 9) begin nerr++;
        $display("FAIL max_full got ch=%0d f=%0d cyc=%0d exp ch=2 f=520200 cyc=9", pc[0], pf[0], pcy[0]); end
      nchk++; if (pc[1] != 2 || pf[1] != 8 || pcy[1] != 17) begin nerr++;
        $display("FAIL max_after_clear got ch=%0d f=%0d cyc=%0d exp ch=2 f=8 cyc=17", pc[1], pf[1], pcy[1]); end
    end
  endtask

  task automatic test_clear();
    int pc[$], pcy[$];
    longint pf[$];
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); #1;
      req_valid = (c < 13) ? 4'b0010 : 4'b0000;
      req_a[15:8] = (c < 5) ? 8'd3 : 8'd2;
      clr = (c == 5) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      nchk++; if ({out_valid, out_ch, out_f} !== {e_ov, 2'(e_ch), AW'(e_f)}) begin nerr++;
        $display("FAIL clr_out c=%0d got v=%b ch=%0d f=%0d exp v=%b ch=%0d f=%0d", c, out_valid, out_ch, out_f, e_ov, e_ch, e_f); end
      if (out_valid) begin pc.push_back(int'(out_ch)); pf.push_back(longint'(out_f)); pcy.push_back(c); end
    end
    nchk++;
    if (pc.size() != 1) begin nerr++; $display("FAIL clr_count got=%0d exp=1", pc.size()); end
    else begin
      nchk++; if (pc[0] != 1 || pf[0] != 32 || pcy[0] != 14) begin nerr++;
        $display("FAIL clr_result got ch=%0d f=%0d cyc=%0d exp ch=1 f=32 cyc=14", pc[0], pf[0], pcy[0]); end
    end
  endtask

  task automatic test_enable_reset();
    int a[8], b[3], v[8], cnt[NCH];
    longint s0, s1;
    int n0;
    logic [NCH-1:0] lg;
    s0 = 0; s1 = 0; n0 = 0;
    for (int k = 0; k < 8; k++) begin
      a[k] = $urandom_range(1, 255); s0 += longint'(a[k]) * a[k];
      v[k] = $urandom_range(0, 255); s1 += longint'(v[k]) * v[k];
    end
    for (int k = 0; k < 3; k++) b[k] = $urandom_range(0, 255);
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      enable = !(c >= 8 && c <= 10);
      req_valid = 4'b0001;
      if (c < 8)       req_a[7:0] = 8'(a[c]);
      else if (c < 12) req_a[7:0] = 8'(b[0]);
      else             req_a[7:0] = 8'(b[c - 11]);
      @(negedge clk);
      nchk++; if (req_ready !== exp_ready()) begin nerr++; $display("FAIL en_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready()); end
      if (c >= 8 && c <= 10) begin
        nchk++; if (req_ready !== 4'b0000) begin nerr++; $display("FAIL en_blocked c=%0d got=%b exp=0000", c, req_ready); end
      end
      if (c == 9) begin
        nchk++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_f !== AW'(s0)) begin nerr++;
          $display("FAIL en_inflight got v=%b ch=%0d f=%0d exp v=1 ch=0 f=%0d", out_valid, out_ch, out_f, s0); end
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    #3 rst_n = 1'b0;
    #1;
    nchk++; if ({out_valid, out_ch, out_f, req_ready} !== '0) begin nerr++;
      $display("FAIL async_reset got v=%b ch=%0d f=%0d rdy=%b exp all 0", out_valid, out_ch, out_f, req_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1; enable = 1'b1; req_valid = '1;
    req_a = {8'd7, 8'd6, 8'd5, 8'(v[0])};
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    @(negedge clk);
    nchk++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL rr_after_reset got=%b exp=0001", req_ready); end
    lg = exp_ready();
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NCH; i++) begin
        if (lg[i]) cnt[i]++;
        req_valid[i] = (cnt[i] < 8);
      end
      if (cnt[0] < 8) req_a[7:0] = 8'(v[cnt[0]]);
      @(negedge clk);
      lg = exp_ready();
      nchk++; if (req_ready !== lg) begin nerr++; $display("FAIL post_reset_ready c=%0d got=%b exp=%b", c, req_ready, lg); end
      nchk++; if ({out_valid, out_ch, out_f} !== {e_ov, 2'(e_ch), AW'(e_f)}) begin nerr++;
        $display("FAIL post_reset_out c=%0d got v=%b ch=%0d f=%0d exp v=%b ch=%0d f=%0d", c, out_valid, out_ch, out_f, e_ov, e_ch, e_f); end
      if (out_valid && out_ch == 2'd0) begin
        n0++;
        nchk++; if (out_f !== AW'(s1)) begin nerr++; $display("FAIL fresh_block got f=%0d exp f=%0d", out_f, s1); end
      end
    end
    nchk++; if (n0 != 1) begin nerr++; $display("FAIL fresh_block_count got=%0d exp=1", n0); end
  endtask

  task automatic test_random();
    logic [NCH-1:0] lg;
    lg = '0;
    for (int c = 0; c < 420; c++) begin
      @(posedge clk); #1;
      if (c < 400) begin
        for (int i = 0; i < NCH; i++) begin
          if (!req_valid[i] || lg[i]) begin
            req_valid[i] = ($urandom_range(0, 2) != 0);
            req_a[i*DW +: DW] = 8'($urandom);
          end
          clr[i] = ($urandom_range(0, 19) == 0);
        end
        enable = ($urandom_range(0, 7) != 0);
      end else begin
        req_valid = '0; clr = '0; enable = 1'b1;
      end
      @(negedge clk);
      lg = exp_ready();
      nchk++; if (req_ready !== lg) begin nerr++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, lg); end
      nchk++; if ({out_valid, out_ch, out_f} !== {e_ov, 2'(e_ch), AW'(e_f)}) begin nerr++;
        $display("FAIL rand_out c=%0d got v=%b ch=%0d f=%0d exp v=%b ch=%0d f=%0d", c, out_valid, out_ch, out_f, e_ov, e_ch, e_f); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_max();
    test_clear();
    test_enable_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", nchk, nerr);
    $fatal(1);
  end
endmodule
